// File: rtl/tensor_core_mac_engine.sv
// tensor_core_mac_engine
//   Multi-lane sequential matrix multiply-accumulate engine: C = A*B or
//   C = D + A*B on DIM x DIM unsigned matrices. LANES MAC units each own one
//   output element and iterate over k; elements finish in row-major groups.
//   Results are written either wrapped (low DATA_WIDTH bits) or clamped.
// Ports:
//   clock_in, reset_in          clock (rising edge), async active-high reset
//   start                       run request, sampled while not busy
//   accumulate_mode             0: C=A*B, 1: C=D+A*B (captured at start)
//   saturate_enable             0: wrap, 1: clamp (captured at start)
//   tensor_core_input1/2/3      matrices A, B, D
//   tensor_core_output          registered result matrix C
//   busy                        high while a run is in progress
//   is_done_with_calculation    sticky completion flag
//   overflow_flag               sticky, some element exceeded 2^DATA_WIDTH-1
module tensor_core_mac_engine #(
  parameter int DIM        = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(DIM) + 1
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start,
  input  logic                  accumulate_mode,
  input  logic                  saturate_enable,
  input  logic [DATA_WIDTH-1:0] tensor_core_input1 [DIM][DIM],
  input  logic [DATA_WIDTH-1:0] tensor_core_input2 [DIM][DIM],
  input  logic [DATA_WIDTH-1:0] tensor_core_input3 [DIM][DIM],
  output logic [DATA_WIDTH-1:0] tensor_core_output [DIM][DIM],
  output logic                  busy,
  output logic                  is_done_with_calculation,
  output logic                  overflow_flag
);

  localparam int KW  = $clog2(DIM);
  localparam int NEL = DIM*DIM;
  localparam int EW  = $clog2(NEL);
  localparam logic [KW-1:0]        K_LAST    = KW'(DIM-1);
  localparam logic [EW-1:0]        LAST_BASE = EW'(NEL-LANES);
  localparam logic [EW-1:0]        LANE_STEP = EW'(LANES);
  localparam logic [ACC_WIDTH-1:0] MAX_VAL   =
    {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [EW-1:0]          base_q, base_d;
  logic                   mode_q, mode_d, sat_q, sat_d;
  logic                   busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]  opa_q [DIM][DIM], opa_d [DIM][DIM];
  logic [DATA_WIDTH-1:0]  opb_q [DIM][DIM], opb_d [DIM][DIM];
  logic [DATA_WIDTH-1:0]  opd_q [DIM][DIM], opd_d [DIM][DIM];
  logic [DATA_WIDTH-1:0]  out_q [DIM][DIM], out_d [DIM][DIM];
  logic [ACC_WIDTH-1:0]   acc_q [LANES], acc_d [LANES];

  logic [EW-1:0]          elem_s [LANES];
  logic [KW-1:0]          row_s  [LANES], col_s [LANES];
  logic [ACC_WIDTH-1:0]   init_s [LANES], prod_s [LANES], sum_s [LANES];

  // Wrap or clamp a full-precision sum to the output element width.
  function automatic logic [DATA_WIDTH-1:0] fit_result(
    input logic [ACC_WIDTH-1:0] sum,
    input logic                 sat
  );
    if (sat && (sum > MAX_VAL)) begin
      return {DATA_WIDTH{1'b1}};
    end else begin
      return sum[DATA_WIDTH-1:0];
    end
  endfunction

  // Per-lane datapath: element coordinates, product and running sum for this k.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      elem_s[l] = base_q + EW'(l);
      row_s[l]  = KW'(32'(elem_s[l]) / DIM);
      col_s[l]  = KW'(32'(elem_s[l]) % DIM);
      prod_s[l] = ACC_WIDTH'(opa_q[row_s[l]][k_q]) * ACC_WIDTH'(opb_q[k_q][col_s[l]]);
      if (mode_q) begin
        init_s[l] = ACC_WIDTH'(opd_q[row_s[l]][col_s[l]]);
      end else begin
        init_s[l] = {ACC_WIDTH{1'b0}};
      end
      if (k_q == KW'(0)) begin
        sum_s[l] = init_s[l] + prod_s[l];
      end else begin
        sum_s[l] = acc_q[l] + prod_s[l];
      end
    end
  end

  // Next-state, snapshot capture and result write-back.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    mode_d  = mode_q;
    sat_d   = sat_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opd_d   = opd_q;
    out_d   = out_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opa_d   = tensor_core_input1;
          opb_d   = tensor_core_input2;
          opd_d   = tensor_core_input3;
          mode_d  = accumulate_mode;
          sat_d   = saturate_enable;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          k_d     = KW'(0);
          base_d  = EW'(0);
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          acc_d[l] = sum_s[l];
          if (k_q == K_LAST) begin
            out_d[row_s[l]][col_s[l]] = fit_result(sum_s[l], sat_q);
            if (sum_s[l] > MAX_VAL) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d = ovf_d;
            end
          end else begin
            acc_d[l] = sum_s[l];
          end
        end
        if (k_q == K_LAST) begin
          k_d = KW'(0);
          if (base_q == LAST_BASE) begin
            base_d  = EW'(0);
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            base_d = base_q + LANE_STEP;
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, operand snapshot and result registers.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      k_q     <= KW'(0);
      base_q  <= EW'(0);
      mode_q  <= 1'b0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      opa_q   <= '{default: '0};
      opb_q   <= '{default: '0};
      opd_q   <= '{default: '0};
      out_q   <= '{default: '0};
      acc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      opd_q   <= opd_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
    end
  end

  assign tensor_core_output       = out_q;
  assign busy                     = busy_q;
  assign is_done_with_calculation = done_q;
  assign overflow_flag            = ovf_q;

endmodule

// File: doc/tensor_core_mac_engine.md
Name: tensor_core_mac_engine

Overview:
Parametrised, multi-lane successor to the 4x4 sequential tensor core. It computes C = A*B or C = D + A*B for DIM x DIM unsigned matrices, using LANES multiply-accumulate units that iterate over k. It adds a start/busy/done handshake, operand snapshotting, an accumulate mode, selectable wrap or saturate output, and an overflow flag. It sits between the tensor core register file and the result writeback path.

Parameters:
DIM, 4, matrix dimension (>=2).
DATA_WIDTH, 8, element width of A, B, D and C (unsigned).
LANES, 1, output elements computed in parallel; must divide DIM*DIM.
ACC_WIDTH, 2*DATA_WIDTH+$clog2(DIM)+1, internal accumulator width; no internal overflow.

Ports:
clock_in  input  1  sole clock, rising edge
reset_in  input  1  asynchronous, active-high reset
start  input  1  request; sampled on the rising edge while not busy
accumulate_mode  input  1  0: C=A*B; 1: C=D+A*B; captured at start
saturate_enable  input  1  0: wrap (truncate); 1: clamp to 2^DATA_WIDTH-1; captured at start
tensor_core_input1  input  [DATA_WIDTH-1:0] [DIM][DIM]  matrix A
tensor_core_input2  input  [DATA_WIDTH-1:0] [DIM][DIM]  matrix B
tensor_core_input3  input  [DATA_WIDTH-1:0] [DIM][DIM]  addend D
tensor_core_output  output  [DATA_WIDTH-1:0] [DIM][DIM]  result C, registered
busy  output  1  high while computing
is_done_with_calculation  output  1  sticky completion flag
overflow_flag  output  1  sticky; set if any element exceeded 2^DATA_WIDTH-1 before wrap/clamp

Behaviour:
- Reset (asynchronous, any time, including mid-run): state=IDLE, all outputs 0, all counters 0, operand snapshot cleared.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge T:
  - Snapshot A, B, D, accumulate_mode and saturate_enable.
  - Clear is_done_with_calculation and overflow_flag; set busy.
  - Set k=0 and element base=0, then enter RUN.
- RUN, each edge: lane l (0..LANES-1) owns element e=base+l, with row i=e/DIM and column j=e%DIM.
  - On k==0, the accumulator is loaded with (accumulate_mode ? D[i][j] : 0) + A[i][0]*B[0][j].
  - On later k, it adds A[i][k]*B[k][j].
  - On k==DIM-1, the lane writes the final sum to tensor_core_output[i][j]: low DATA_WIDTH bits, or clamped when saturate_enable=1.
  - overflow_flag is ORed with (sum > 2^DATA_WIDTH-1).
  - Then k=0 and base+=LANES; otherwise k++.
- Elements complete in row-major order, in groups of LANES.
- Latency: the final write occurs at edge T+DIM^3/LANES.
  - On that same edge: state=DONE, busy=0, is_done_with_calculation=1.
  - Example: DIM=4, LANES=1 gives 64 cycles; LANES=4 gives 16.
- Elements not yet rewritten keep their previous value during RUN. Consumers must wait for done.
- start while busy is ignored; the run continues unaffected.
- Input changes after the start edge do not affect the result (snapshot).
- DONE holds outputs and flags until the next accepted start or reset. start is a level sample, so holding start high in DONE restarts immediately.
- All arithmetic is unsigned. Products are 2*DATA_WIDTH bits, and sums are carried in ACC_WIDTH.

Test Plan:
1. DIM=4, LANES=1, A=identity, B[i][j]=4i+j, mode 0, one-cycle start -> busy high for 64 cycles; done at T+64; C==B; overflow_flag=0.
2. A=B=all 2, D=all 5, accumulate_mode=1 -> every C element = 21; an immediate restart with mode 0 gives all 16, with done low for the 64 run cycles.
3. A=B=all 255, mode 0:
   - saturate_enable=0 -> every C = 0x04 (260100 mod 256), overflow_flag=1.
   - saturate_enable=1 -> every C = 255, overflow_flag=1.
4. start pulsed at cycle 10 of a run and inputs changed at cycle 5 -> done still at T+64, result matches the snapshot operands, no second run.
5. reset_in asserted asynchronously mid-cycle at run cycle 20 -> busy, done, overflow_flag and all C are 0 immediately; a new start afterwards completes correctly in 64 cycles.
6. LANES=4 and LANES=16 builds, test 1 stimulus -> done at T+16 and T+4 respectively; C==B.
